// File: rtl/friet_state_axi4_lite_responder.sv
// AXI4-Lite register front end holding the Friet permutation state for an attached core.
// Latency: write valids -> ready +1, bvalid +2; arvalid -> arready +1, rvalid +2. Backpressure: one transaction in flight, ready held low while busy.
module friet_state_axi4_lite_responder #(
    parameter int STATE_SIZE = 384
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [3:0]            s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [3:0]            s_axi_araddr,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic                  core_start,
    output logic [STATE_SIZE-1:0] core_state,
    input  logic                  core_done,
    input  logic [STATE_SIZE-1:0] core_result
);
    localparam int WORD = 32;

    localparam logic [1:0] ADDR_POP  = 2'd0;
    localparam logic [1:0] ADDR_PUSH = 2'd1;
    localparam logic [1:0] ADDR_CTRL = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, WACK, WRESP, RACK, RDATA, BUSY} state_t;

    state_t                state;
    logic [STATE_SIZE-1:0] state_buf;
    logic [1:0]            req_addr;
    logic [31:0]           req_wdata;
    logic                  launch_pending;
    logic                  busy;

    assign busy       = (state == BUSY);
    assign core_state = state_buf;

    logic unused_ok;
    assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_wstrb,
                         s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state          <= IDLE;
            state_buf      <= '0;
            req_addr       <= '0;
            req_wdata      <= '0;
            launch_pending <= 1'b0;
            s_axi_awready  <= 1'b0;
            s_axi_wready   <= 1'b0;
            s_axi_bvalid   <= 1'b0;
            s_axi_bresp    <= RESP_OKAY;
            s_axi_arready  <= 1'b0;
            s_axi_rvalid   <= 1'b0;
            s_axi_rresp    <= RESP_OKAY;
            s_axi_rdata    <= '0;
            core_start     <= 1'b0;
        end else begin
            core_start <= 1'b0;
            case (state)
                IDLE: begin
                    // Address and data must arrive together; a pending write beats a read.
                    if (s_axi_awvalid && s_axi_wvalid) begin
                        req_addr      <= s_axi_awaddr[3:2];
                        req_wdata     <= s_axi_wdata;
                        s_axi_awready <= 1'b1;
                        s_axi_wready  <= 1'b1;
                        state         <= WACK;
                    end else if (s_axi_arvalid) begin
                        req_addr      <= s_axi_araddr[3:2];
                        s_axi_arready <= 1'b1;
                        state         <= RACK;
                    end
                end
                WACK: begin
                    s_axi_awready  <= 1'b0;
                    s_axi_wready   <= 1'b0;
                    s_axi_bvalid   <= 1'b1;
                    s_axi_bresp    <= RESP_OKAY;
                    launch_pending <= 1'b0;
                    state          <= WRESP;
                    case (req_addr)
                        ADDR_PUSH: state_buf      <= {req_wdata, state_buf[STATE_SIZE-1:WORD]};
                        ADDR_CTRL: launch_pending <= req_wdata[0];
                        default:   s_axi_bresp    <= RESP_SLVERR;
                    endcase
                end
                WRESP: begin
                    if (s_axi_bready) begin
                        s_axi_bvalid <= 1'b0;
                        if (launch_pending) begin
                            core_start <= 1'b1;
                            state      <= BUSY;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                RACK: begin
                    s_axi_arready <= 1'b0;
                    s_axi_rvalid  <= 1'b1;
                    state         <= RDATA;
                    case (req_addr)
                        ADDR_POP: begin
                            s_axi_rdata <= state_buf[WORD-1:0];
                            s_axi_rresp <= RESP_OKAY;
                        end
                        ADDR_CTRL: begin
                            s_axi_rdata <= {31'b0, busy};
                            s_axi_rresp <= RESP_OKAY;
                        end
                        default: begin
                            s_axi_rdata <= '0;
                            s_axi_rresp <= RESP_SLVERR;
                        end
                    endcase
                end
                RDATA: begin
                    // The pop only consumes the word once the master has taken it.
                    if (s_axi_rready) begin
                        s_axi_rvalid <= 1'b0;
                        if (req_addr == ADDR_POP) begin
                            state_buf <= {state_buf[WORD-1:0], state_buf[STATE_SIZE-1:WORD]};
                        end
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    if (core_done) begin
                        state_buf <= core_result;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_friet_state_axi4_lite_responder.sv
// Directed-sequence bench with random data, checked against a word-queue model of the state buffer.
module tb_friet_state_axi4_lite_responder;
    localparam int S = 384;
    localparam int NW = S / 32;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [3:0]    s_axi_awaddr;
    logic [2:0]    s_axi_awprot;
    logic          s_axi_awvalid;
    logic          s_axi_awready;
    logic [31:0]   s_axi_wdata;
    logic [3:0]    s_axi_wstrb;
    logic          s_axi_wvalid;
    logic          s_axi_wready;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_bvalid;
    logic          s_axi_bready;
    logic [3:0]    s_axi_araddr;
    logic [2:0]    s_axi_arprot;
    logic          s_axi_arvalid;
    logic          s_axi_arready;
    logic [31:0]   s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rvalid;
    logic          s_axi_rready;
    logic          core_start;
    logic [S-1:0]  core_state;
    logic          core_done;
    logic [S-1:0]  core_result;

    int n_asserts = 0;
    int n_fail = 0;

    logic [31:0] mq[$];
    logic [1:0]  resp;
    logic [31:0] rd;
    logic [31:0] w0;
    logic [31:0] w1;

    always #5 aclk = ~aclk;

    friet_state_axi4_lite_responder #(.STATE_SIZE(S)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .core_start(core_start), .core_state(core_state),
        .core_done(core_done), .core_result(core_result)
    );

    task automatic check(input string tag, input logic [S-1:0] obs, input logic [S-1:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model: mq[0] is the word in bits [31:0].
    task automatic model_push(input logic [31:0] w);
        void'(mq.pop_front());
        mq.push_back(w);
    endtask

    task automatic model_pop(output logic [31:0] w);
        w = mq.pop_front();
        mq.push_back(w);
    endtask

    function automatic logic [S-1:0] model_vec();
        logic [S-1:0] v;
        v = '0;
        for (int i = 0; i < NW; i++) v[i*32 +: 32] = mq[i];
        return v;
    endfunction

    task automatic model_clear();
        mq.delete();
        for (int i = 0; i < NW; i++) mq.push_back(32'h0);
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input int hold,
                             output logic [1:0] r);
        int n;
        s_axi_awaddr = addr; s_axi_wdata = data;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
        n = 0;
        do begin @(posedge aclk); #1; n++; end while (!(s_axi_awready && s_axi_wready) && n < 20);
        check("aw_ready_latency", n, 1);
        @(posedge aclk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        check("bvalid_rise", s_axi_bvalid, 1'b1);
        r = s_axi_bresp;
        repeat (hold) begin
            @(posedge aclk); #1;
            check("bvalid_hold", s_axi_bvalid, 1'b1);
            check("bresp_hold", s_axi_bresp, r);
        end
        s_axi_bready = 1'b1; @(posedge aclk); #1; s_axi_bready = 1'b0;
        check("bvalid_fall", s_axi_bvalid, 1'b0);
    endtask

    task automatic axi_read(input logic [3:0] addr, input int hold,
                            output logic [31:0] d, output logic [1:0] r);
        int n;
        s_axi_araddr = addr; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
        n = 0;
        do begin @(posedge aclk); #1; n++; end while (!s_axi_arready && n < 20);
        check("ar_ready_latency", n, 1);
        @(posedge aclk); #1;
        s_axi_arvalid = 1'b0;
        check("rvalid_rise", s_axi_rvalid, 1'b1);
        d = s_axi_rdata; r = s_axi_rresp;
        repeat (hold) begin
            @(posedge aclk); #1;
            check("rvalid_hold", s_axi_rvalid, 1'b1);
            check("rdata_hold", s_axi_rdata, d);
        end
        s_axi_rready = 1'b1; @(posedge aclk); #1; s_axi_rready = 1'b0;
        check("rvalid_fall", s_axi_rvalid, 1'b0);
    endtask

    task automatic push_word(input logic [31:0] w);
        logic [1:0] r;
        axi_write(4'h4, w, $urandom_range(0, 1), r);
        check("push_resp", r, 2'b00);
        model_push(w);
    endtask

    task automatic pop_all(input string tag);
        logic [31:0] d;
        logic [31:0] e;
        logic [1:0]  r;
        for (int i = 0; i < NW; i++) begin
            axi_read(4'h0, $urandom_range(0, 2), d, r);
            model_pop(e);
            check(tag, d, e);
            check("pop_resp", r, 2'b00);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awready"}, s_axi_awready, 1'b0);
        check({tag, "_wready"}, s_axi_wready, 1'b0);
        check({tag, "_arready"}, s_axi_arready, 1'b0);
        check({tag, "_bvalid"}, s_axi_bvalid, 1'b0);
        check({tag, "_rvalid"}, s_axi_rvalid, 1'b0);
        check({tag, "_core_start"}, core_start, 1'b0);
        check({tag, "_bresp"}, s_axi_bresp, 2'b00);
        check({tag, "_rresp"}, s_axi_rresp, 2'b00);
        check({tag, "_rdata"}, s_axi_rdata, 32'h0);
        check({tag, "_core_state"}, core_state, '0);
    endtask

    initial begin
        aresetn = 1'b0;
        s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        core_done = 1'b0; core_result = '0;
        model_clear();
        repeat (3) @(posedge aclk);
        #1;
        check_reset_outputs("reset");
        aresetn = 1'b1;
        @(posedge aclk); #1;

        // Counting pattern, two full passes.
        for (int i = 0; i < NW; i++) push_word(i);
        check("load_state", core_state, model_vec());
        pop_all("count_pass1");
        pop_all("count_pass2");

        // Random state with random read backpressure.
        for (int i = 0; i < NW; i++) push_word($urandom);
        check("rand_state", core_state, model_vec());
        pop_all("rand_pass");

        // Launch the core; arvalid is held during BUSY to probe arready.
        for (int i = 0; i < NW; i++) push_word($urandom);
        axi_write(4'h8, 32'h1, 0, resp);
        check("launch_resp", resp, 2'b00);
        check("core_start_pulse", core_start, 1'b1);
        check("core_state_at_start", core_state, model_vec());
        s_axi_araddr = 4'h0; s_axi_arvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge aclk); #1;
            check("core_start_single", core_start, 1'b0);
            check("busy_arready", s_axi_arready, 1'b0);
            check("busy_awready", s_axi_awready, 1'b0);
            check("busy_state_stable", core_state, model_vec());
        end
        core_result = ~core_state; core_done = 1'b1;
        foreach (mq[i]) mq[i] = ~mq[i];
        @(posedge aclk); #1;
        core_done = 1'b0;
        check("arready_after_done_1", s_axi_arready, 1'b0);
        @(posedge aclk); #1;
        check("arready_after_done_2", s_axi_arready, 1'b1);
        @(posedge aclk); #1;
        s_axi_arvalid = 1'b0;
        check("result_rvalid", s_axi_rvalid, 1'b1);
        rd = s_axi_rdata;
        model_pop(w0);
        check("result_word0", rd, w0);
        s_axi_rready = 1'b1; @(posedge aclk); #1; s_axi_rready = 1'b0;
        pop_all("result_pass");

        // Error responses leave the buffer alone.
        axi_write(4'hC, 32'hDEADBEEF, 0, resp);
        check("wr_c_resp", resp, 2'b10);
        axi_read(4'hC, 0, rd, resp);
        check("rd_c_resp", resp, 2'b10);
        check("rd_c_data", rd, 32'h0);
        axi_write(4'h0, $urandom, 1, resp);
        check("wr_0_resp", resp, 2'b10);
        axi_read(4'h4, 1, rd, resp);
        check("rd_4_resp", resp, 2'b10);
        check("rd_4_data", rd, 32'h0);
        axi_read(4'h8, 0, rd, resp);
        check("status_resp", resp, 2'b00);
        check("status_data", rd, 32'h0);
        check("err_state_kept", core_state, model_vec());

        // Write backpressure with the next write already presented.
        w0 = $urandom; w1 = $urandom;
        s_axi_awaddr = 4'h4; s_axi_wdata = w0;
        s_axi_awvalid = 1'b1; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
        @(posedge aclk); #1;
        check("bp_awready", s_axi_awready, 1'b1);
        @(posedge aclk); #1;
        model_push(w0);
        s_axi_wdata = w1;
        check("bp_bvalid", s_axi_bvalid, 1'b1);
        check("bp_bresp", s_axi_bresp, 2'b00);
        for (int k = 0; k < 3; k++) begin
            @(posedge aclk); #1;
            check("bp_bvalid_hold", s_axi_bvalid, 1'b1);
            check("bp_bresp_hold", s_axi_bresp, 2'b00);
            check("bp_awready_low", s_axi_awready, 1'b0);
        end
        s_axi_bready = 1'b1; @(posedge aclk); #1; s_axi_bready = 1'b0;
        check("bp_awready_idle", s_axi_awready, 1'b0);
        @(posedge aclk); #1;
        check("bp_awready_next", s_axi_awready, 1'b1);
        model_push(w1);
        @(posedge aclk); #1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        check("bp_bvalid_next", s_axi_bvalid, 1'b1);
        s_axi_bready = 1'b1; @(posedge aclk); #1; s_axi_bready = 1'b0;
        check("bp_state", core_state, model_vec());

        // Control write with bit 0 clear does nothing.
        axi_write(4'h8, 32'hFFFF_FFFE, 0, resp);
        check("nolaunch_resp", resp, 2'b00);
        check("nolaunch_start", core_start, 1'b0);
        @(posedge aclk); #1;
        check("nolaunch_start_next", core_start, 1'b0);
        axi_read(4'h8, 0, rd, resp);
        check("nolaunch_status", rd, 32'h0);

        // core_done while idle is ignored.
        core_result = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        core_done = 1'b1;
        @(posedge aclk); #1;
        core_done = 1'b0;
        check("idle_done_ignored", core_state, model_vec());
        pop_all("idle_done_pass");

        // Reset in the middle of BUSY, then a stale core_done.
        for (int i = 0; i < NW; i++) push_word($urandom | 32'h1);
        axi_write(4'h8, 32'h1, 0, resp);
        check("rst_launch_start", core_start, 1'b1);
        @(posedge aclk); #1;
        aresetn = 1'b0;
        #1;
        check_reset_outputs("midbusy_reset");
        model_clear();
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        core_result = '1; core_done = 1'b1;
        @(posedge aclk); #1;
        core_done = 1'b0;
        check("stale_done_ignored", core_state, '0);
        check("stale_done_start", core_start, 1'b0);
        axi_read(4'h8, 0, rd, resp);
        check("post_reset_status", rd, 32'h0);
        check("post_reset_status_resp", resp, 2'b00);
        axi_read(4'h0, 0, rd, resp);
        model_pop(w0);
        check("post_reset_word", rd, w0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
